// File: rtl/mdu_issue_ctrl_if.sv
// Handshake bundle between the execute stage, the multiply/divide unit and the
// issue controller that sequences one M-extension op at a time.
interface mdu_issue_ctrl_if;
    // Execute-stage request side
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall;

    // Writeback response side
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_err;

    // MDU side
    logic        mdu_start;
    logic [2:0]  mdu_operation;
    logic [31:0] mdu_in_x;
    logic [31:0] mdu_in_y;
    logic        mdu_done;
    logic [31:0] mdu_out;

    // Pipeline plus MDU environment driving the controller
    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush,
        output mdu_done, mdu_out,
        input  stall, resp_valid, resp_data, resp_rd, resp_err,
        input  mdu_start, mdu_operation, mdu_in_x, mdu_in_y
    );

    // The issue controller itself
    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush,
        input  mdu_done, mdu_out,
        output stall, resp_valid, resp_data, resp_rd, resp_err,
        output mdu_start, mdu_operation, mdu_in_x, mdu_in_y
    );
endinterface

// File: rtl/mdu_issue_ctrl.sv
// Issue controller for an iterative multiply/divide unit: accepts one op, pulses
// start, waits for completion or timeout, and returns a single-cycle response.
module mdu_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    mdu_issue_ctrl_if.slave    bus
);

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        DRAIN = 3'd4
    } state_e;

    state_e      state_q,     state_d;
    logic [2:0]  op_q,        op_d;
    logic [31:0] x_q,         x_d;
    logic [31:0] y_q,         y_d;
    logic [4:0]  rd_q,        rd_d;
    logic [31:0] cnt_q,       cnt_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_rd_q,   resp_rd_d;
    logic        resp_err_q,  resp_err_d;

    logic        stall_c;
    logic        resp_valid_c;
    logic        mdu_start_c;
    logic        timeout;

    // In DRAIN the count may already sit past the limit if the flush landed on
    // the final WAIT cycle, so the compare is inclusive.
    assign timeout = (cnt_q >= TIMEOUT_LAST);

    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d      = state_q;
        op_d         = op_q;
        x_d          = x_q;
        y_d          = y_q;
        rd_d         = rd_q;
        cnt_d        = cnt_q;
        resp_data_d  = resp_data_q;
        resp_rd_d    = resp_rd_q;
        resp_err_d   = resp_err_q;
        stall_c      = 1'b0;
        resp_valid_c = 1'b0;
        mdu_start_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && !bus.flush) begin
                    stall_c = 1'b1;
                    op_d    = bus.req_funct3;
                    x_d     = bus.req_rs1;
                    y_d     = bus.req_rs2;
                    rd_d    = bus.req_rd;
                    state_d = ISSUE;
                end
            end

            ISSUE: begin
                stall_c     = 1'b1;
                mdu_start_c = 1'b1;
                cnt_d       = '0;
                state_d     = bus.flush ? DRAIN : WAIT;
            end

            WAIT: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 32'd1;
                if (bus.mdu_done) begin
                    // A flush racing completion just abandons the finished result.
                    if (bus.flush) begin
                        state_d = IDLE;
                    end else begin
                        resp_data_d = bus.mdu_out;
                        resp_err_d  = 1'b0;
                        resp_rd_d   = rd_q;
                        state_d     = RESP;
                    end
                end else if (bus.flush) begin
                    state_d = DRAIN;
                end else if (timeout) begin
                    resp_data_d = '0;
                    resp_err_d  = 1'b1;
                    resp_rd_d   = rd_q;
                    state_d     = RESP;
                end
            end

            RESP: begin
                resp_valid_c = !bus.flush;
                state_d      = IDLE;
            end

            DRAIN: begin
                stall_c = 1'b1;
                cnt_d   = cnt_q + 32'd1;
                if (bus.mdu_done || timeout) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= '0;
            x_q         <= '0;
            y_q         <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            resp_data_q <= '0;
            resp_rd_q   <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            x_q         <= x_d;
            y_q         <= y_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_rd_q   <= resp_rd_d;
            resp_err_q  <= resp_err_d;
        end
    end

    // Stall in IDLE follows req_valid combinationally, so it is masked by reset
    // to keep it low while reset is held.
    assign bus.stall         = stall_c && !reset;
    assign bus.resp_valid    = resp_valid_c;
    assign bus.mdu_start     = mdu_start_c;
    assign bus.mdu_operation = op_q;
    assign bus.mdu_in_x      = x_q;
    assign bus.mdu_in_y      = y_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_rd       = resp_rd_q;
    assign bus.resp_err      = resp_err_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl: inputs change 2 ns after a rising edge and
// outputs are compared 1 ns later, well clear of the next edge.
module tb_mdu_issue_ctrl;

    localparam int TO = 8;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   start_cnt;
    int   resp_cnt;
    int   s0;
    int   r0;
    int   early;

    mdu_issue_ctrl_if bus ();

    mdu_issue_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle
    always @(negedge clk) begin
        if (!reset) begin
            start_cnt <= start_cnt + int'(bus.mdu_start);
            resp_cnt  <= resp_cnt + int'(bus.resp_valid);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_rd     = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total = 0; bad = 0; start_cnt = 0; resp_cnt = 0;
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_funct3 = '0; bus.req_rs1 = '0; bus.req_rs2 = '0;
        bus.req_rd = '0; bus.flush = 1'b0; bus.mdu_done = 1'b0; bus.mdu_out = '0;

        // Reset state, including stall held low against a live request
        tick(); tick();
        bus.req_valid = 1'b1; #1;
        check("rst_stall", bus.stall, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_start", bus.mdu_start, 0);
        check("rst_op", bus.mdu_operation, 0);
        check("rst_x", bus.mdu_in_x, 0);
        check("rst_y", bus.mdu_in_y, 0);
        check("rst_data", bus.resp_data, 0);
        check("rst_rd", bus.resp_rd, 0);
        check("rst_err", bus.resp_err, 0);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        tick();

        // MUL 5*3 -> 15, done in the fourth WAIT cycle
        s0 = start_cnt; r0 = resp_cnt;
        drive_req(3'b000, 32'd5, 32'd3, 5'd4); #1;
        check("mul_stall_idle", bus.stall, 1);
        tick(); bus.req_valid = 1'b0; #1;
        check("mul_start", bus.mdu_start, 1);
        check("mul_op", bus.mdu_operation, 0);
        check("mul_x", bus.mdu_in_x, 5);
        check("mul_y", bus.mdu_in_y, 3);
        tick(); #1;
        check("mul_start_once", bus.mdu_start, 0);
        check("mul_stall_wait", bus.stall, 1);
        tick(); tick(); tick();
        bus.mdu_done = 1'b1; bus.mdu_out = 32'd15; #1;
        check("mul_no_early_resp", bus.resp_valid, 0);
        check("mul_x_stable", bus.mdu_in_x, 5);
        tick(); bus.mdu_done = 1'b0; #1;
        check("mul_resp_valid", bus.resp_valid, 1);
        check("mul_resp_data", bus.resp_data, 15);
        check("mul_resp_rd", bus.resp_rd, 4);
        check("mul_resp_err", bus.resp_err, 0);
        check("mul_stall_resp", bus.stall, 0);
        tick(); #1;
        check("mul_resp_one_cycle", bus.resp_valid, 0);
        check("mul_data_hold", bus.resp_data, 15);
        check("mul_starts", start_cnt - s0, 1);
        check("mul_resps", resp_cnt - r0, 1);

        // DIV 15/3 then DIVU 15/4 back-to-back at minimum latency
        s0 = start_cnt; r0 = resp_cnt;
        drive_req(3'b100, 32'd15, 32'd3, 5'd7);
        tick();
        drive_req(3'b101, 32'd15, 32'd4, 5'd8); #1;
        check("div_op_latched", bus.mdu_operation, 4);
        check("div_y_latched", bus.mdu_in_y, 3);
        tick(); bus.mdu_done = 1'b1; bus.mdu_out = 32'd5; #1;
        check("div_y_stable", bus.mdu_in_y, 3);
        tick(); bus.mdu_done = 1'b0; #1;
        check("div_resp_valid", bus.resp_valid, 1);
        check("div_resp_data", bus.resp_data, 5);
        check("div_resp_rd", bus.resp_rd, 7);
        check("div_no_accept_in_resp", bus.mdu_start, 0);
        check("div_stall_resp", bus.stall, 0);
        tick(); #1;
        check("divu_stall_idle", bus.stall, 1);
        check("divu_no_start_idle", bus.mdu_start, 0);
        tick(); bus.req_valid = 1'b0; #1;
        check("divu_start", bus.mdu_start, 1);
        check("divu_op", bus.mdu_operation, 5);
        check("divu_y", bus.mdu_in_y, 4);
        tick(); bus.mdu_done = 1'b1; bus.mdu_out = 32'd3;
        tick(); bus.mdu_done = 1'b0; #1;
        check("divu_resp_valid", bus.resp_valid, 1);
        check("divu_resp_data", bus.resp_data, 3);
        check("divu_resp_rd", bus.resp_rd, 8);
        tick();
        check("div_starts", start_cnt - s0, 2);
        check("div_resps", resp_cnt - r0, 2);

        // Flush in the second WAIT cycle, done four cycles later, result dropped
        r0 = resp_cnt;
        drive_req(3'b000, 32'd9, 32'd9, 5'd3);
        tick(); bus.req_valid = 1'b0;
        tick(); tick(); bus.flush = 1'b1;
        tick(); bus.flush = 1'b0; #1;
        check("flush_drain_stall", bus.stall, 1);
        tick(); tick(); tick();
        bus.mdu_done = 1'b1; bus.mdu_out = 32'd81; #1;
        check("flush_stall_until_done", bus.stall, 1);
        check("flush_no_resp", bus.resp_valid, 0);
        tick(); bus.mdu_done = 1'b0; #1;
        check("flush_stall_released", bus.stall, 0);
        check("flush_data_hold", bus.resp_data, 3);
        check("flush_resps", resp_cnt - r0, 0);
        drive_req(3'b000, 32'd2, 32'd2, 5'd9);
        tick(); bus.req_valid = 1'b0;
        tick(); bus.mdu_done = 1'b1; bus.mdu_out = 32'd4;
        tick(); bus.mdu_done = 1'b0; #1;
        check("post_flush_valid", bus.resp_valid, 1);
        check("post_flush_data", bus.resp_data, 4);
        check("post_flush_rd", bus.resp_rd, 9);
        tick();

        // Timeout: no done for TO WAIT cycles
        drive_req(3'b000, 32'd7, 32'd7, 5'd10);
        tick(); bus.req_valid = 1'b0;
        early = 0;
        for (int i = 0; i < TO; i++) begin
            tick(); #1;
            if (bus.resp_valid || !bus.stall) early++;
        end
        check("to_wait_quiet", early, 0);
        tick(); #1;
        check("to_resp_valid", bus.resp_valid, 1);
        check("to_resp_err", bus.resp_err, 1);
        check("to_resp_data", bus.resp_data, 0);
        check("to_resp_rd", bus.resp_rd, 10);
        tick(); #1;
        check("to_err_hold", bus.resp_err, 1);

        // Done on the timeout cycle wins over the timeout
        drive_req(3'b001, 32'd1, 32'd1, 5'd11);
        tick(); bus.req_valid = 1'b0;
        for (int i = 0; i < TO; i++) tick();
        bus.mdu_done = 1'b1; bus.mdu_out = 32'h1234;
        tick(); bus.mdu_done = 1'b0; #1;
        check("prio_resp_valid", bus.resp_valid, 1);
        check("prio_resp_err", bus.resp_err, 0);
        check("prio_resp_data", bus.resp_data, 32'h1234);
        tick();

        // Flush in RESP suppresses the pulse; flush in IDLE blocks acceptance
        drive_req(3'b000, 32'd3, 32'd4, 5'd12);
        tick(); bus.req_valid = 1'b0;
        tick(); bus.mdu_done = 1'b1; bus.mdu_out = 32'd12;
        tick(); bus.mdu_done = 1'b0; bus.flush = 1'b1; #1;
        check("resp_flush_valid", bus.resp_valid, 0);
        tick(); bus.req_valid = 1'b1; #1;
        check("idle_flush_stall", bus.stall, 0);
        tick(); bus.req_valid = 1'b0; bus.flush = 1'b0; #1;
        check("idle_flush_no_start", bus.mdu_start, 0);
        check("idle_flush_idle", bus.stall, 0);
        tick();

        // Flush during ISSUE goes to DRAIN and leaves by timeout
        r0 = resp_cnt;
        drive_req(3'b010, 32'd6, 32'd6, 5'd14);
        tick(); bus.req_valid = 1'b0; bus.flush = 1'b1; #1;
        check("issue_flush_start", bus.mdu_start, 1);
        tick(); bus.flush = 1'b0; #1;
        check("issue_flush_drain", bus.stall, 1);
        for (int i = 0; i < TO - 1; i++) tick();
        #1;
        check("drain_last_stall", bus.stall, 1);
        tick(); #1;
        check("drain_exit_stall", bus.stall, 0);
        check("drain_resps", resp_cnt - r0, 0);

        // Same-cycle done and flush in WAIT: back to IDLE, no response
        r0 = resp_cnt;
        drive_req(3'b000, 32'd8, 32'd8, 5'd15);
        tick(); bus.req_valid = 1'b0;
        tick(); bus.mdu_done = 1'b1; bus.flush = 1'b1; bus.mdu_out = 32'd64;
        tick(); bus.mdu_done = 1'b0; bus.flush = 1'b0; #1;
        check("race_stall", bus.stall, 0);
        check("race_resp_valid", bus.resp_valid, 0);
        bus.req_valid = 1'b1; #1;
        check("race_idle_accepts", bus.stall, 1);
        bus.req_valid = 1'b0;
        tick();
        check("race_resps", resp_cnt - r0, 0);

        // Reset mid-WAIT clears outputs without a clock edge
        r0 = resp_cnt;
        drive_req(3'b100, 32'd100, 32'd7, 5'd12);
        tick(); bus.req_valid = 1'b0;
        tick(); tick(); #1;
        reset = 1'b1; #1;
        check("amid_stall", bus.stall, 0);
        check("amid_x", bus.mdu_in_x, 0);
        check("amid_y", bus.mdu_in_y, 0);
        check("amid_op", bus.mdu_operation, 0);
        check("amid_data", bus.resp_data, 0);
        check("amid_rd", bus.resp_rd, 0);
        tick();
        reset = 1'b0;
        bus.mdu_done = 1'b1; bus.mdu_out = 32'd99;
        tick(); bus.mdu_done = 1'b0; #1;
        check("late_done_resp", bus.resp_valid, 0);
        check("late_done_stall", bus.stall, 0);
        check("late_done_resps", resp_cnt - r0, 0);
        drive_req(3'b111, 32'd7, 32'd3, 5'd13);
        tick(); bus.req_valid = 1'b0; #1;
        check("remu_start", bus.mdu_start, 1);
        check("remu_op", bus.mdu_operation, 7);
        tick(); bus.mdu_done = 1'b1; bus.mdu_out = 32'd1;
        tick(); bus.mdu_done = 1'b0; #1;
        check("remu_valid", bus.resp_valid, 1);
        check("remu_data", bus.resp_data, 1);
        check("remu_rd", bus.resp_rd, 13);
        check("remu_err", bus.resp_err, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
